// File: rtl/sw_pkg.sv
// Shared definitions for the switch debounce blocks: FSM encoding and defaults.
package sw_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        JUDGE = 2'd2
    } state_t;

    // Clock cycles per 1 us tick for the usual system clock.
    localparam int          CNT1US_DEF  = 107;
    // Typical settle window in us for panel switches.
    localparam logic [15:0] DEB_LEN_DEF = 16'd30;

endpackage

// File: rtl/sw_deb_sched_rr_arb.sv
// NCH-way round-robin arbiter: picks the first requester at or after ptr.
// Purely combinational so the caller can grant in the same cycle.
module rr_arb #(
    parameter int NCH = 4,
    parameter int CHW = 2
) (
    input  logic [NCH-1:0] req,
    input  logic [CHW-1:0] ptr,
    output logic           gnt_valid,
    output logic [CHW-1:0] gnt_idx
);

    logic [CHW-1:0] idx;

    // Walk the request vector starting at ptr, wrapping modulo NCH.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        idx       = '0;
        for (int k = 0; k < NCH; k++) begin
            idx = CHW'((int'(ptr) + k) % NCH);
            if (!gnt_valid && req[idx]) begin
                gnt_valid = 1'b1;
                gnt_idx   = idx;
            end
        end
    end

endmodule

// File: rtl/sw_deb_sched.sv
// Debounce scheduler: NCH active-low switches share one settle timer.
// Falling edges queue as pending requests; a round-robin arbiter picks one
// channel, its settle window is timed in 1 us units, then its level is judged.
module sw_deb_sched
    import sw_pkg::*;
#(
    parameter int NCH    = 4,
    parameter int CNT1US = CNT1US_DEF,
    parameter int CHW    = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    input  logic [NCH-1:0] sw_in,
    input  logic [15:0]    deb_len,
    output logic [NCH-1:0] key_pulse,
    output logic [NCH-1:0] key_level,
    output logic           reject,
    output logic           busy,
    output logic [CHW-1:0] cur_ch
);

    localparam int PW = (CNT1US > 1) ? $clog2(CNT1US) : 1;

    logic [NCH-1:0] s_meta, s_sync, s_d, fall;
    logic [NCH-1:0] pend, pend_n, active_mask;
    logic [NCH-1:0] key_pulse_n, key_level_n;
    logic [CHW-1:0] rr_ptr, rr_ptr_n, cur_ch_n;
    logic [15:0]    len_q, len_n, us_q, us_n;
    logic [PW-1:0]  pre_q, pre_n;
    logic           reject_n, busy_n;
    logic           gnt_valid;
    logic [CHW-1:0] gnt_idx;
    state_t         state, state_n;

    // Two-flop synchroniser plus one delay flop for edge detection.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            // Released level, so a switch already held at reset is seen as a fresh press.
            s_meta <= '1;
            s_sync <= '1;
            s_d    <= '1;
        end else begin
            s_meta <= sw_in;
            s_sync <= s_meta;
            s_d    <= s_sync;
        end
    end

    assign fall = s_d & ~s_sync;

    rr_arb #(.NCH(NCH), .CHW(CHW)) u_arb (
        .req       (pend),
        .ptr       (rr_ptr),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    // Next-state, timer and output decode for the grant/wait/judge sequence.
    always_comb begin
        state_n     = state;
        pend_n      = pend;
        rr_ptr_n    = rr_ptr;
        cur_ch_n    = cur_ch;
        len_n       = len_q;
        us_n        = us_q;
        pre_n       = pre_q;
        busy_n      = busy;
        key_pulse_n = '0;
        reject_n    = 1'b0;
        active_mask = '0;
        // Releases clear the level immediately; a judge only sets a channel that reads low.
        key_level_n = key_level & ~s_sync;

        if (!en) begin
            state_n = IDLE;
            pend_n  = '0;
            busy_n  = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt_valid) begin
                        state_n              = WAIT;
                        cur_ch_n             = gnt_idx;
                        len_n                = (deb_len == 16'd0) ? 16'd1 : deb_len;
                        us_n                 = '0;
                        pre_n                = '0;
                        busy_n               = 1'b1;
                        pend_n[gnt_idx]      = 1'b0;
                        active_mask[gnt_idx] = 1'b1;
                    end
                end
                WAIT: begin
                    active_mask[cur_ch] = 1'b1;
                    if (s_sync[cur_ch]) begin
                        // Contact bounced open inside the window: give up early.
                        reject_n = 1'b1;
                        busy_n   = 1'b0;
                        state_n  = IDLE;
                    end else if (pre_q == PW'(CNT1US - 1)) begin
                        pre_n = '0;
                        if (us_q + 16'd1 == len_q) begin
                            state_n = JUDGE;
                        end else begin
                            us_n = us_q + 16'd1;
                        end
                    end else begin
                        pre_n = pre_q + PW'(1);
                    end
                end
                JUDGE: begin
                    active_mask[cur_ch] = 1'b1;
                    if (!s_sync[cur_ch]) begin
                        key_pulse_n[cur_ch] = 1'b1;
                        key_level_n[cur_ch] = 1'b1;
                    end else begin
                        reject_n = 1'b1;
                    end
                    rr_ptr_n = (cur_ch == CHW'(NCH - 1)) ? '0 : cur_ch + CHW'(1);
                    busy_n   = 1'b0;
                    state_n  = IDLE;
                end
                default: state_n = IDLE;
            endcase
            // Bounces on the channel being served must not re-queue it.
            pend_n = pend_n | (fall & ~active_mask);
        end
    end

    // State, timer and registered output update.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            pend      <= '0;
            rr_ptr    <= '0;
            cur_ch    <= '0;
            len_q     <= '0;
            us_q      <= '0;
            pre_q     <= '0;
            busy      <= 1'b0;
            key_pulse <= '0;
            key_level <= '0;
            reject    <= 1'b0;
        end else begin
            state     <= state_n;
            pend      <= pend_n;
            rr_ptr    <= rr_ptr_n;
            cur_ch    <= cur_ch_n;
            len_q     <= len_n;
            us_q      <= us_n;
            pre_q     <= pre_n;
            busy      <= busy_n;
            key_pulse <= key_pulse_n;
            key_level <= key_level_n;
            reject    <= reject_n;
        end
    end

endmodule

// File: tb/tb_sw_deb_sched.sv
// Scoreboard bench for sw_deb_sched (NCH=4, CNT1US=4). Stimulus pushes the
// expected press/reject events with their cycle stamps; a monitor pops and
// compares whenever the DUT raises key_pulse or reject.
module tb_sw_deb_sched;

    localparam int NCH = 4;
    localparam int CNT = 4;
    localparam int CHW = 2;

    typedef struct {
        bit is_rej;
        int ch;
        int at;
    } ev_t;

    logic           clk = 1'b0;
    logic           rst;
    logic           en;
    logic [NCH-1:0] sw_in;
    logic [15:0]    deb_len;
    logic [NCH-1:0] key_pulse, key_level;
    logic           reject, busy;
    logic [CHW-1:0] cur_ch;

    int  cyc    = 0;
    int  checks = 0;
    int  errors = 0;
    ev_t exp_q[$];

    sw_deb_sched #(.NCH(NCH), .CNT1US(CNT), .CHW(CHW)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .sw_in     (sw_in),
        .deb_len   (deb_len),
        .key_pulse (key_pulse),
        .key_level (key_level),
        .reject    (reject),
        .busy      (busy),
        .cur_ch    (cur_ch)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every strobe from the DUT must match the oldest queued expectation.
    always @(negedge clk) begin
        if (key_pulse != '0 || reject) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", int'(key_pulse), 0);
                check("unexpected_reject", int'(reject), 0);
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                check("pulse_vec", int'(key_pulse), e.is_rej ? 0 : (1 << e.ch));
                check("reject", int'(reject), int'(e.is_rej));
                check("event_cycle", cyc, e.at);
                if (e.is_rej) check("busy_at_reject", int'(busy), 0);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [NCH-1:0] m);
        sw_in = sw_in & ~m;
    endtask

    task automatic release_sw(input logic [NCH-1:0] m);
        sw_in = sw_in | m;
    endtask

    task automatic expect_ev(input bit is_rej, input int ch, input int at);
        ev_t e;
        e.is_rej = is_rej;
        e.ch     = ch;
        e.at     = at;
        exp_q.push_back(e);
    endtask

    // Bounded wait for all queued events to be seen.
    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            tick(1);
            n++;
        end
        check("drain_pending", exp_q.size(), 0);
        tick(2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        rst     = 1'b1;
        en      = 1'b1;
        sw_in   = '1;
        deb_len = 16'd3;
        tick(3);
        rst = 1'b0;
        tick(1);
        check("rst_key_pulse", int'(key_pulse), 0);
        check("rst_key_level", int'(key_level), 0);
        check("rst_reject", int'(reject), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_cur_ch", int'(cur_ch), 0);

        // Simultaneous ch0/ch3 from rr_ptr=0: ch0 first, ch3 one window later.
        tick(2);
        t0 = cyc;
        press(4'b1001);
        expect_ev(1'b0, 0, t0 + 17);
        expect_ev(1'b0, 3, t0 + 31);
        tick(6);
        check("sim_busy", int'(busy), 1);
        check("sim_cur_ch", int'(cur_ch), 0);
        drain();
        check("sim_level", int'(key_level), 4'b1001);
        release_sw(4'b1001);
        tick(5);
        check("sim_release", int'(key_level), 0);

        // Clean press on ch1, deb_len=3.
        t0 = cyc;
        press(4'b0010);
        expect_ev(1'b0, 1, t0 + 17);
        tick(10);
        check("clean_busy", int'(busy), 1);
        check("clean_cur_ch", int'(cur_ch), 1);
        drain();
        check("clean_level", int'(key_level), 4'b0010);
        release_sw(4'b0010);
        tick(5);

        // Single ch0 press moves the pointer to ch1.
        t0 = cyc;
        press(4'b0001);
        expect_ev(1'b0, 0, t0 + 17);
        drain();
        release_sw(4'b0001);
        tick(5);

        // Simultaneous ch0/ch1 with rr_ptr=1: ch1 served first.
        t0 = cyc;
        press(4'b0011);
        expect_ev(1'b0, 1, t0 + 17);
        expect_ev(1'b0, 0, t0 + 31);
        tick(6);
        check("rr_cur_ch", int'(cur_ch), 1);
        drain();
        check("rr_level", int'(key_level), 4'b0011);
        release_sw(4'b0011);
        tick(5);

        // Glitch on ch2: low 5 cycles, abort during WAIT.
        t0 = cyc;
        press(4'b0100);
        tick(5);
        release_sw(4'b0100);
        expect_ev(1'b1, 2, t0 + 8);
        drain();
        check("glitch_level", int'(key_level), 0);
        check("glitch_busy", int'(busy), 0);

        // deb_len=0 acts as 1 us; a mid-window change has no effect.
        deb_len = 16'd0;
        t0 = cyc;
        press(4'b0100);
        expect_ev(1'b0, 2, t0 + 9);
        tick(5);
        deb_len = 16'd100;
        drain();
        check("len0_level", int'(key_level), 4'b0100);
        release_sw(4'b0100);
        deb_len = 16'd3;
        tick(5);

        // en drop during WAIT on ch1 with ch2 pending; ch0 held pressed.
        t0 = cyc;
        press(4'b0001);
        expect_ev(1'b0, 0, t0 + 17);
        drain();
        check("en_hold_level", int'(key_level), 4'b0001);
        press(4'b0010);
        tick(2);
        press(4'b0100);
        tick(6);
        check("en_wait_busy", int'(busy), 1);
        check("en_wait_cur_ch", int'(cur_ch), 1);
        en = 1'b0;
        tick(1);
        check("en_busy", int'(busy), 0);
        check("en_state", int'(dut.state), 0);
        check("en_pend", int'(dut.pend), 0);
        release_sw(4'b0001);
        tick(5);
        check("en_release_level", int'(key_level), 0);
        en = 1'b1;
        tick(20);
        check("en_no_regrant", int'(busy), 0);
        release_sw(4'b0110);
        tick(5);

        // Synchronous reset in the middle of a WAIT on ch3.
        t0 = cyc;
        press(4'b1000);
        tick(6);
        check("rst_pre_cur_ch", int'(cur_ch), 3);
        tick(2);
        rst = 1'b1;
        release_sw(4'b1000);
        tick(1);
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_cur_ch", int'(cur_ch), 0);
        check("mid_rst_level", int'(key_level), 0);
        check("mid_rst_pulse", int'(key_pulse), 0);
        check("mid_rst_reject", int'(reject), 0);
        check("mid_rst_rr_ptr", int'(dut.rr_ptr), 0);
        check("mid_rst_pend", int'(dut.pend), 0);
        rst = 1'b0;
        tick(3);
        t0 = cyc;
        press(4'b0010);
        expect_ev(1'b0, 1, t0 + 17);
        drain();
        check("post_rst_level", int'(key_level), 4'b0010);
        release_sw(4'b0010);
        tick(5);

        check("queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
